tdc_readout_arbiter: RTL

Round-robin readout scheduler that shares the single serial `DATA_OUT` line of `tdc_top` between NCH TDC channel hit buffers. It grants one pending channel at a time, acknowledges (pops) its timestamp word, and serializes a framed record at one bit per `CLK`. It sits between the per-channel TDC hit FIFOs and the `DATA_OUT` pad, in the `CLK` domain.

---
 rtl/tdc_readout_arbiter_if.sv | 24 ++
 rtl/tdc_readout_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/tdc_readout_arbiter_if.sv
// Readout bus between the per-channel TDC hit FIFOs, the arbiter and the DATA_OUT pad.
// The master side is the arbiter; the slave side is the requester/pad environment.
interface tdc_readout_arbiter_if #(
  parameter int NCH      = 4,
  parameter int TS_WIDTH = 16
);
  logic                    ENABLE;
  logic [NCH-1:0]          HIT_VALID;
  logic [NCH*TS_WIDTH-1:0] HIT_TS;
  logic [NCH-1:0]          HIT_ACK;
  logic                    DATA_OUT;
  logic                    BUSY;
  logic [15:0]             FRAME_CNT;

  modport master (
    input  ENABLE, HIT_VALID, HIT_TS,
    output HIT_ACK, DATA_OUT, BUSY, FRAME_CNT
  );

  modport slave (
    output ENABLE, HIT_VALID, HIT_TS,
    input  HIT_ACK, DATA_OUT, BUSY, FRAME_CNT
  );
endinterface

// File: rtl/tdc_readout_arbiter.sv
// Round-robin readout scheduler: grants one pending TDC channel at a time, pops its
// head timestamp and serializes {1, channel id, timestamp} MSB first on DATA_OUT,
// followed by one idle gap cycle.
module tdc_readout_arbiter #(
  parameter int NCH      = 4,
  parameter int TS_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESETB,
  tdc_readout_arbiter_if.master bus
);
  localparam int CH_W  = $clog2(NCH);
  localparam int FLEN  = 1 + CH_W + TS_WIDTH;
  localparam int CNT_W = $clog2(FLEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [FLEN-1:0]  sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [CH_W-1:0]  last;
  logic [CH_W-1:0]  win;
  logic [CH_W-1:0]  cand;
  logic             found;
  logic             grant;
  logic             last_bit;
  logic             load_sr;
  logic             shift_sr;
  logic             clr_sr;

  // Round-robin search starting one past the last granted channel; first valid wins.
  always_comb begin
    found = 1'b0;
    win   = last;
    cand  = last;
    for (int i = 1; i <= NCH; i++) begin
      cand = last + CH_W'(i);
      if (!found && bus.HIT_VALID[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // GAP grants exactly like IDLE so back-to-back frames are FLEN+1 cycles apart.
  assign grant    = bus.ENABLE && found && (state != SHIFT);
  assign last_bit = (bit_cnt == CNT_W'(FLEN - 1));

  // State register; BUSY is registered from the next state so it tracks state exactly.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state    <= IDLE;
      bus.BUSY <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus.BUSY <= (state_nxt != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, GAP: state_nxt = grant ? SHIFT : IDLE;
      SHIFT:     if (last_bit) state_nxt = GAP;
      default:   state_nxt = IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state.
  always_comb begin
    load_sr  = grant;
    shift_sr = (state == SHIFT) && !last_bit;
    clr_sr   = (state == SHIFT) && last_bit;
  end

  // Shift register, bit counter, RR pointer, pop strobe and frame counter.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      sr            <= '0;
      bit_cnt       <= '0;
      last          <= CH_W'(NCH - 1);
      bus.HIT_ACK   <= '0;
      bus.FRAME_CNT <= '0;
    end else begin
      bus.HIT_ACK <= '0;
      if (load_sr) begin
        sr            <= {1'b1, win, bus.HIT_TS[win*TS_WIDTH +: TS_WIDTH]};
        bit_cnt       <= '0;
        last          <= win;
        bus.HIT_ACK   <= NCH'(1) << win;
        bus.FRAME_CNT <= bus.FRAME_CNT + 16'd1;
      end else if (shift_sr) begin
        sr      <= {sr[FLEN-2:0], 1'b0};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (clr_sr) begin
        sr <= '0;
      end
    end
  end

  assign bus.DATA_OUT = sr[FLEN-1];

endmodule
